// File: rtl/result_collector.sv
// Result collector: first-word-fall-through FIFO for 5-bit compute results,
// with a saturating running sum of accepted results and a sticky drop flag.
module result_collector #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [4:0]    result_in,
  input  logic          valid_in,
  input  logic          clear,
  input  logic          out_ready,
  output logic [4:0]    out_data,
  output logic          out_valid,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic [7:0]    sum,
  output logic          overflow
);
  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]         wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            sum_q, sum_d;
  logic                  ovf_q, ovf_d;
  logic [DEPTH-1:0][4:0] mem_q;
  logic                  pop, push, drop;
  logic [8:0]            sum_wide;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign out_valid = ~empty;
  assign out_data  = out_valid ? mem_q[rptr_q] : 5'd0;
  assign count     = count_q;
  assign sum       = sum_q;
  assign overflow  = ovf_q;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign pop      = out_valid & out_ready;
  assign push     = valid_in & (~full | pop) & ~clear;
  assign drop     = valid_in & full & ~pop;
  assign sum_wide = {1'b0, sum_q} + {4'b0, result_in};

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      sum_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      // DEPTH is a power of two, so pointer wrap is plain overflow.
      if (push) wptr_d = wptr_q + AW'(1);
      if (pop)  rptr_d = rptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (push) sum_d = sum_wide[8] ? 8'hff : sum_wide[7:0];
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever shown.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= result_in;
  end

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: driver keeps an occupancy/sum model,
// monitor pops expected data on every handshake and checks visible state.
module tb_result_collector;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clock = 1'b0;
  logic          rst_n = 1'b1;
  logic [4:0]    result_in = '0;
  logic          valid_in = 1'b0, clear = 1'b0, out_ready = 1'b0;
  logic [4:0]    out_data;
  logic          out_valid, full, empty, overflow;
  logic [CW-1:0] count;
  logic [7:0]    sum;

  result_collector #(.DEPTH(DEPTH)) dut (
    .clock(clock), .rst_n(rst_n), .result_in(result_in), .valid_in(valid_in),
    .clear(clear), .out_ready(out_ready), .out_data(out_data),
    .out_valid(out_valid), .count(count), .full(full), .empty(empty),
    .sum(sum), .overflow(overflow)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [4:0] exp_q[$];
  int         mcount = 0;
  int         msum   = 0;
  bit         movf   = 0;
  bit         mon_en = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the effect of one clock edge under the given inputs to the model.
  task automatic commit(input bit v, input int d, input bit c, input bit r);
    bit p, f, acc;
    p = (mcount > 0) && r;
    f = (mcount == DEPTH);
    if (c) begin
      mcount = 0; msum = 0; movf = 0;
      exp_q.delete();
    end else begin
      acc = v && (!f || p);
      if (acc) begin
        exp_q.push_back(5'(d));
        msum = (msum + d > 255) ? 255 : msum + d;
      end
      if (v && f && !p) movf = 1;
      mcount = mcount + int'(acc) - int'(p);
    end
  endtask

  task automatic cycle(input bit v, input int d, input bit c, input bit r);
    valid_in = v; result_in = 5'(d); clear = c; out_ready = r;
    @(posedge clock);
    #1;
    commit(v, d, c, r);
  endtask

  task automatic do_reset();
    valid_in = 0; clear = 0; out_ready = 0; result_in = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_overflow", int'(overflow), 0);
    mcount = 0; msum = 0; movf = 0;
    exp_q.delete();
    @(posedge clock);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: checks state against the model and data on each handshake.
  always @(negedge clock) begin
    if (mon_en && rst_n) begin
      chk("count", int'(count), mcount);
      chk("sum", int'(sum), msum);
      chk("overflow", int'(overflow), int'(movf));
      chk("out_valid", int'(out_valid), int'(mcount != 0));
      chk("full", int'(full), int'(mcount == DEPTH));
      chk("empty", int'(empty), int'(mcount == 0));
      if (!out_valid) chk("idle_data", int'(out_data), 0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_pop", 1, 0);
        else chk("pop_data", int'(out_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    @(posedge clock);
    #1;
    do_reset();
    mon_en = 1;

    // Buffer three, then drain in order.
    cycle(1, 5, 0, 0); cycle(1, 17, 0, 0); cycle(1, 31, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1);
    chk("t1_empty", int'(empty), 1);
    chk("t1_sum", int'(sum), 53);

    // Asynchronous reset with three entries held.
    cycle(1, 3, 0, 0); cycle(1, 4, 0, 0); cycle(1, 6, 0, 0);
    chk("pre_rst_count", int'(count), 3);
    do_reset();

    // Fill, then drop one.
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0);
    chk("t2_full", int'(full), 1);
    chk("t2_count", int'(count), 4);
    cycle(1, 9, 0, 0);
    chk("t2_ovf", int'(overflow), 1);
    chk("t2_count_hold", int'(count), 4);
    chk("t2_sum", int'(sum), 10);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);

    // Full with simultaneous pop and push.
    for (int i = 1; i <= 4; i++) cycle(1, i, 0, 0);
    cycle(1, 7, 0, 1);
    chk("t3_count", int'(count), 4);
    chk("t3_ovf", int'(overflow), 0);
    chk("t3_head", int'(out_data), 2);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 1);
    cycle(0, 0, 1, 0);

    // Saturation and pointer wrap at full throughput.
    for (int i = 1; i <= 9; i++) begin
      cycle(1, 31, 0, 1);
      if (i == 8) chk("t4_sum8", int'(sum), 248);
      if (i == 9) chk("t4_sum9", int'(sum), 255);
    end
    for (int i = 0; i < 20; i++) cycle(1, int'($urandom_range(0, 31)), 0, 1);
    chk("t4_sum_sat", int'(sum), 255);
    for (int i = 0; i < 2; i++) cycle(0, 0, 0, 1);

    // Clear beats a concurrent result and a pending overflow.
    for (int i = 1; i <= 4; i++) cycle(1, i + 10, 0, 0);
    cycle(1, 30, 0, 0);
    cycle(0, 0, 0, 1); cycle(0, 0, 0, 1);
    chk("t5_pre_count", int'(count), 2);
    chk("t5_pre_ovf", int'(overflow), 1);
    cycle(1, 9, 1, 0);
    chk("t5_count", int'(count), 0);
    chk("t5_sum", int'(sum), 0);
    chk("t5_ovf", int'(overflow), 0);
    chk("t5_valid", int'(out_valid), 0);
    cycle(1, 12, 0, 0);
    chk("t5_data", int'(out_data), 12);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 9) < 7), int'($urandom_range(0, 31)),
            ($urandom_range(0, 63) == 0), ($urandom_range(0, 1) == 1));
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 1);
    chk("final_empty", int'(empty), 1);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_collector.md
# result_collector

Downstream stage for the four-operand capture/compute block. It consumes the 5-bit `result` / one-cycle `valid` pulse pair and buffers each result in a small first-word-fall-through FIFO. A consumer drains the FIFO through a ready/valid handshake. The block also keeps a saturating running sum of accepted results and a sticky overflow flag for results that arrive when the FIFO is full.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CW`, $clog2(DEPTH+1): width of `count`, derived; do not override.
- `clock`  in  1  rising-edge clock; the only clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `result_in`  in  5  result from the compute stage.
- `valid_in`  in  1  result strobe; one cycle per result, and may be high on back-to-back cycles.
- `clear`  in  1  synchronous clear of FIFO, sum and overflow.
- `out_ready`  in  1  consumer accepts head entry.
- `out_data`  out  5  head entry; 0 when empty.
- `out_valid`  out  1  FIFO non-empty.
- `count`  out  CW  entries held, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `sum`  out  8  saturating sum of all accepted results since reset/clear.
- `overflow`  out  1  sticky; set when a result was dropped.

## Operation
- Reset (`rst_n`=0, any time, including mid-transfer):
  - read and write pointers = 0, count = 0, sum = 0, overflow = 0;
  - therefore out_valid = 0, out_data = 0, empty = 1, full = 0;
  - storage contents are don't-care.
- pop = out_valid & out_ready.
- push = valid_in & (~full | pop).
  - A full FIFO accepts a new result in the same cycle the head is popped.
- Dropped result:
  - Condition: valid_in & full & ~pop.
  - No storage or pointer change; overflow ← 1.
  - overflow holds until reset or clear.
- push: mem[wptr] ← result_in; wptr ← wptr+1 mod DEPTH.
- pop: rptr ← rptr+1 mod DEPTH.
- count update:
  - +1 on push only;
  - −1 on pop only;
  - unchanged on both or neither.
- Pointers wrap silently, and the FIFO must behave correctly across any number of wraps.
- Sum:
  - On push, sum ← min(sum + result_in, 255), computed at 9-bit width.
  - Dropped results are not added; pops do not change sum.
- clear = 1:
  - pointers, count, sum and overflow are all set to 0;
  - it takes priority over push, pop and drop in the same cycle;
  - the concurrent valid_in result is discarded and does not set overflow.
- out_data = mem[rptr] when out_valid, else 5'd0. It is combinational from registered state only, with no path from result_in.
- out_ready while empty: no effect.

## Timing
- All state changes on the rising edge of `clock`, except reset, which acts immediately.
- Push-to-visible latency is 1 cycle. A result pushed at edge N appears on out_data/out_valid after edge N if the FIFO was empty.
- Pop takes effect at the edge where out_valid & out_ready. The next entry, or empty, is presented after that edge.
- count, full, empty and sum are registered or decoded from registers; they update 1 cycle after the causing event.
- overflow asserts after the edge that drops the result.
- Sustained throughput is 1 result/cycle when out_ready is held high.
- No combinational path from any input to any output except out_ready → nothing. Outputs depend only on state.

## Test plan
- Reset values: assert rst_n=0 mid-run with 3 entries held → immediately count=0, empty=1, out_valid=0, out_data=0, sum=0, overflow=0.
- Push 5, 17, 31 on consecutive cycles with out_ready=0, then raise out_ready → out_data sequence 5, 17, 31 over three cycles, then empty=1; sum=53.
- Push 1, 2, 3, 4 → full=1, count=4. Push 9 with out_ready=0 → overflow=1, count stays 4, sum=10, drain yields 1, 2, 3, 4.
- FIFO full, out_ready=1 and valid_in with 7 in the same cycle → count stays 4, head advances, 7 is drained last, overflow stays 0.
- Push 31 nine times while draining continuously → sum reads 248 after the 8th push and 255 after the 9th. Drive 20 further pushes (pointer wrap) → data order preserved, sum holds 255.
- With 2 entries held and overflow=1, assert clear together with valid_in=1 → count=0, sum=0, overflow=0, out_valid=0. Next cycle, push 12 → out_data=12 the following cycle.
